// File: rtl/screen_ram_pkg.sv
// screen_ram_pkg: shared owner encoding and starvation counter width for the screen RAM arbiter
package screen_ram_pkg;
  typedef enum logic {OWN_CPU = 1'b0, OWN_SCR = 1'b1} owner_t;
  localparam int STARVE_CNT_W = 8;
endpackage

// File: rtl/screen_ram_arbiter_rr_arb2.sv
// rr_arb2: two-request round-robin picker; req[0] is the CPU, req[1] the screen, urgent forces the screen
module rr_arb2
  import screen_ram_pkg::*;
(
  input  logic [1:0] req,
  input  logic       urgent,
  input  owner_t     last,
  output logic [1:0] gnt
);
  always_comb begin
    gnt[0] = req[0] & (~req[1] | (~urgent & (last == OWN_SCR)));
    gnt[1] = req[1] & (~req[0] | urgent | (last == OWN_CPU));
  end
endmodule

// File: rtl/screen_ram_arbiter.sv
// screen_ram_arbiter: shares one synchronous RAM port between CPU and VGA fetcher, tagging reads by owner.
// Define SCREEN_RAM_ARB_STATS_EN to add the 32-bit conflict_count output.
module screen_ram_arbiter
  import screen_ram_pkg::*;
#(
  parameter int RAM_WIDTH          = 16,
  parameter int RAM_REGISTER_COUNT = 256,
  parameter int STARVE_LIMIT       = 8,
  localparam int ADDR_W            = $clog2(RAM_REGISTER_COUNT)
) (
  input  logic                 CLK_50,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic [RAM_WIDTH-1:0] cpu_wdata,
  output logic                 cpu_gnt,
  output logic                 cpu_rvalid,
  output logic [RAM_WIDTH-1:0] cpu_rdata,
  output logic                 cpu_starved,
  input  logic                 scr_req,
  input  logic                 scr_urgent,
  input  logic [ADDR_W-1:0]    scr_addr,
  output logic                 scr_gnt,
  output logic                 scr_rvalid,
  output logic [RAM_WIDTH-1:0] scr_rdata,
`ifdef SCREEN_RAM_ARB_STATS_EN
  output logic [31:0]          conflict_count,
`endif
  output logic [ADDR_W-1:0]    ram_addr,
  output logic                 ram_we,
  output logic [RAM_WIDTH-1:0] ram_wdata,
  input  logic [RAM_WIDTH-1:0] ram_rdata
);
  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);
  logic [1:0]              gnt;
  owner_t                  last_q, last_d, rd_owner_q, rd_owner_d;
  logic                    rd_valid_q, rd_valid_d, starved_q, starved_d;
  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;
  rr_arb2 u_arb (
    .req    ({scr_req, cpu_req}),
    .urgent (scr_urgent),
    .last   (last_q),
    .gnt    (gnt)
  );
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      last_q     <= OWN_SCR;
      rd_owner_q <= OWN_SCR;
      rd_valid_q <= 1'b0;
      cnt_q      <= '0;
      starved_q  <= 1'b0;
    end else begin
      last_q     <= last_d;
      rd_owner_q <= rd_owner_d;
      rd_valid_q <= rd_valid_d;
      cnt_q      <= cnt_d;
      starved_q  <= starved_d;
    end
  end
  always_comb begin
    last_d     = cpu_gnt ? OWN_CPU : scr_gnt ? OWN_SCR : last_q;
    rd_valid_d = scr_gnt | (cpu_gnt & ~cpu_we);
    rd_owner_d = scr_gnt ? OWN_SCR : OWN_CPU;
    cnt_d      = (~cpu_req | cpu_gnt) ? '0 : (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    starved_d  = cnt_d >= LIMIT;
  end
  always_comb begin
    cpu_gnt     = gnt[0];
    scr_gnt     = gnt[1];
    ram_addr    = cpu_gnt ? cpu_addr : scr_addr;
    ram_we      = cpu_gnt & cpu_we;
    ram_wdata   = cpu_wdata;
    cpu_rvalid  = rd_valid_q & (rd_owner_q == OWN_CPU);
    scr_rvalid  = rd_valid_q & (rd_owner_q == OWN_SCR);
    cpu_rdata   = ram_rdata;
    scr_rdata   = ram_rdata;
    cpu_starved = starved_q;
  end
`ifdef SCREEN_RAM_ARB_STATS_EN
  logic [31:0] conflict_q;
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) conflict_q <= '0;
    else if (cpu_req & scr_req) conflict_q <= conflict_q + 32'd1;
  end
  assign conflict_count = conflict_q;
`endif
endmodule

// File: tb/tb_screen_ram_arbiter.sv
// tb_screen_ram_arbiter: vector table plus read-data scoreboard for screen_ram_arbiter
module tb_screen_ram_arbiter;
  logic        CLK_50 = 1'b0, reset = 1'b1;
  logic        cpu_req = 0, cpu_we = 0, scr_req = 0, scr_urgent = 0;
  logic [7:0]  cpu_addr = 0, scr_addr = 0, ram_addr;
  logic [15:0] cpu_wdata = 0, cpu_rdata, scr_rdata, ram_wdata, ram_rdata;
  logic        cpu_gnt, cpu_rvalid, cpu_starved, scr_gnt, scr_rvalid, ram_we;
`ifdef SCREEN_RAM_ARB_STATS_EN
  logic [31:0] conflict_count;
`endif
  screen_ram_arbiter dut (
    .CLK_50(CLK_50), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_starved(cpu_starved),
    .scr_req(scr_req), .scr_urgent(scr_urgent), .scr_addr(scr_addr),
    .scr_gnt(scr_gnt), .scr_rvalid(scr_rvalid), .scr_rdata(scr_rdata),
`ifdef SCREEN_RAM_ARB_STATS_EN
    .conflict_count(conflict_count),
`endif
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );
  always #5 CLK_50 = ~CLK_50;
  logic [15:0] mem [256];
  logic [15:0] ref_mem [256];
  always @(posedge CLK_50) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end
  typedef struct {
    logic rst, cr, cw; logic [7:0] ca; logic [15:0] cd;
    logic sr, su; logic [7:0] sa;
    logic ecg, esg, ewe, est;
  } vec_t;
  typedef struct { logic own_scr; logic [15:0] data; } exp_t;
  vec_t vq[$];
  exp_t sbq[$];
  int checks = 0, errors = 0;
  function automatic logic [15:0] init_word(input int i);
    return (i == 5) ? 16'hBEEF : 16'hA000 + 16'(i) * 16'h0101;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask
  task automatic add(input logic rst, cr, cw, input logic [7:0] ca, input logic [15:0] cd,
                     input logic sr, su, input logic [7:0] sa, input logic ecg, esg, ewe, est);
    vq.push_back('{rst, cr, cw, ca, cd, sr, su, sa, ecg, esg, ewe, est});
  endtask
  initial begin
    exp_t e;
    for (int i = 0; i < 256; i++) begin
      mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    //  rst cr cw ca     cd        sr su sa     cg sg we st
    add(1, 1, 0, 8'h05, 16'h0000, 0, 0, 8'h00, 1, 0, 0, 0);
    add(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 0);
    add(1, 1, 0, 8'h06, 16'h0000, 1, 0, 8'h20, 1, 0, 0, 0);
    add(0, 1, 0, 8'h06, 16'h0000, 1, 0, 8'h21, 0, 1, 0, 0);
    add(0, 1, 0, 8'h07, 16'h0000, 1, 0, 8'h21, 1, 0, 0, 0);
    add(0, 1, 0, 8'h08, 16'h0000, 1, 0, 8'h22, 0, 1, 0, 0);
    add(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      add(0, 1, 0, 8'h06, 16'h0000, 1, 1, 8'(8'h30 + i), 0, 1, 0, i >= 8);
    add(0, 1, 0, 8'h06, 16'h0000, 1, 0, 8'h40, 1, 0, 0, 1);
    add(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 0);
    add(0, 1, 1, 8'h10, 16'h1234, 0, 0, 8'h00, 1, 0, 1, 0);
    add(0, 0, 0, 8'h00, 16'h5555, 1, 0, 8'h10, 0, 1, 0, 0);
    add(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 0);
    add(0, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h20, 0, 1, 0, 0);
    add(1, 1, 0, 8'h06, 16'h0000, 1, 0, 8'h21, 1, 0, 0, 0);
    add(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 0);
    add(0, 1, 0, 8'h07, 16'h0000, 0, 1, 8'h50, 1, 0, 0, 0);
    add(0, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h51, 0, 1, 0, 0);
    add(0, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00, 0, 0, 0, 0);
    repeat (3) @(posedge CLK_50);
    @(negedge CLK_50);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("rst_scr_rvalid", 32'(scr_rvalid), 0);
    chk("rst_starved", 32'(cpu_starved), 0);
    @(posedge CLK_50); #1;
    reset = 1'b0;
    foreach (vq[k]) begin
      cpu_req = vq[k].cr; cpu_we = vq[k].cw; cpu_addr = vq[k].ca; cpu_wdata = vq[k].cd;
      scr_req = vq[k].sr; scr_urgent = vq[k].su; scr_addr = vq[k].sa;
      if (vq[k].rst) begin
        reset = 1'b1; #2; reset = 1'b0;
        sbq.delete();
      end
      @(negedge CLK_50);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk($sformatf("v%0d_cpu_rvalid", k), 32'(cpu_rvalid), 32'(!e.own_scr));
        chk($sformatf("v%0d_scr_rvalid", k), 32'(scr_rvalid), 32'(e.own_scr));
        chk($sformatf("v%0d_rdata", k), 32'(e.own_scr ? scr_rdata : cpu_rdata), 32'(e.data));
      end else begin
        chk($sformatf("v%0d_cpu_rvalid", k), 32'(cpu_rvalid), 0);
        chk($sformatf("v%0d_scr_rvalid", k), 32'(scr_rvalid), 0);
      end
      chk($sformatf("v%0d_cpu_gnt", k), 32'(cpu_gnt), 32'(vq[k].ecg));
      chk($sformatf("v%0d_scr_gnt", k), 32'(scr_gnt), 32'(vq[k].esg));
      chk($sformatf("v%0d_ram_we", k), 32'(ram_we), 32'(vq[k].ewe));
      chk($sformatf("v%0d_ram_addr", k), 32'(ram_addr), 32'(vq[k].ecg ? vq[k].ca : vq[k].sa));
      chk($sformatf("v%0d_ram_wdata", k), 32'(ram_wdata), 32'(vq[k].cd));
      chk($sformatf("v%0d_starved", k), 32'(cpu_starved), 32'(vq[k].est));
      if (vq[k].ecg && !vq[k].cw) sbq.push_back('{1'b0, ref_mem[vq[k].ca]});
      if (vq[k].esg) sbq.push_back('{1'b1, ref_mem[vq[k].sa]});
      if (vq[k].ecg && vq[k].cw) ref_mem[vq[k].ca] = vq[k].cd;
      @(posedge CLK_50); #1;
    end
`ifdef SCREEN_RAM_ARB_STATS_EN
    reset = 1'b1; #2; reset = 1'b0;
    cpu_req = 1; cpu_we = 0; scr_req = 1; scr_urgent = 0;
    repeat (5) @(posedge CLK_50);
    #1; cpu_req = 0; scr_req = 0;
    @(negedge CLK_50);
    chk("conflict_5", conflict_count, 32'd5);
    reset = 1'b1; #1;
    chk("conflict_rst", conflict_count, 32'd0);
    reset = 1'b0;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/screen_ram_arbiter.md
# screen_ram_arbiter

Shares the single synchronous port of the display RAM between the CPU load/store path and the VGA screen fetcher. It grants one requester per cycle and muxes address, write-enable and write data onto the RAM port. It also tags each issued read so the returning data reaches its owner. The block sits between the CPU core, the pixel-address generator and `ram`, replacing the dedicated screen port with one arbitrated port.

## Interface
Parameters:
- `RAM_WIDTH`, 16, data word width.
- `RAM_REGISTER_COUNT`, 256, RAM depth; `ADDR_W = $clog2(RAM_REGISTER_COUNT)`.
- `STARVE_LIMIT`, 8, consecutive CPU-lost cycles before `cpu_starved` asserts; range 1..255.

Ports:
- `CLK_50`  in  1  single clock; every register is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_req`  in  1  CPU access request; held with stable `cpu_we/addr/wdata` until `cpu_gnt`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W  CPU word address.
- `cpu_wdata`  in  RAM_WIDTH  CPU write data.
- `cpu_gnt`  out  1  CPU access issued this cycle.
- `cpu_rvalid`  out  1  `cpu_rdata` valid; only after a granted read.
- `cpu_rdata`  out  RAM_WIDTH  CPU read data.
- `cpu_starved`  out  1  CPU lost `STARVE_LIMIT` or more consecutive requesting cycles.
- `scr_req`  in  1  screen fetch request; read only.
- `scr_urgent`  in  1  fetcher deadline; forces screen priority.
- `scr_addr`  in  ADDR_W  screen word address.
- `scr_gnt`  out  1  screen read issued this cycle.
- `scr_rvalid`  out  1  `scr_rdata` valid.
- `scr_rdata`  out  RAM_WIDTH  screen read data.
- `ram_addr`  out  ADDR_W  RAM port address.
- `ram_we`  out  1  RAM port write enable.
- `ram_wdata`  out  RAM_WIDTH  RAM port write data.
- `ram_rdata`  in  RAM_WIDTH  RAM read data, one cycle after address.

## Operation
- Priority state `last_owner ∈ {OWN_CPU, OWN_SCR}` holds the last winner and resets to `OWN_SCR`. It updates only on a grant.
- Grant rules, combinational from requests and `last_owner`:
  - If only one requester is active, it wins.
  - If both are active and `scr_urgent` = 1, screen wins.
  - If both are active and `scr_urgent` = 0, the requester that is not `last_owner` wins (round-robin).
  - If neither is active, there is no grant and `ram_we` = 0.
- `cpu_gnt` and `scr_gnt` are never both 1.
- Port mux: the winner drives `ram_addr`. `ram_we = cpu_gnt & cpu_we`. `ram_wdata = cpu_wdata` at all times. With no grant, `ram_addr` = `scr_addr`.
- Read tag: registered `rd_owner` / `rd_valid` capture any granted read. Next cycle:
  - `cpu_rvalid` = `rd_valid` & (`rd_owner` == OWN_CPU).
  - `scr_rvalid` = `rd_valid` & (`rd_owner` == OWN_SCR).
  - Both `rdata` outputs pass `ram_rdata` through.
- A CPU write completes in its grant cycle and produces no `rvalid`.
- Starvation counter, saturating 8-bit:
  - Increments when `cpu_req` & !`cpu_gnt`.
  - Clears on `cpu_gnt` or when `cpu_req` = 0.
  - `cpu_starved` = (count ≥ `STARVE_LIMIT`), registered.
  - It is advisory only and never overrides `scr_urgent`.

## Timing
- Grant latency is 0 cycles: `gnt` is in the same cycle as `req`.
- Read data latency is exactly 1 cycle after `gnt`. Back-to-back grants give back-to-back `rvalid`s.
- Reset values:
  - `cpu_rvalid`, `scr_rvalid`, `cpu_starved` = 0.
  - `last_owner` = OWN_SCR; starvation count = 0.
- Combinational outputs follow inputs during reset; no grant is suppressed.
- Reset asserted with a read in flight: that `rvalid` is dropped, and the requester must reissue.
- The first tie after reset goes to the CPU.

## Configuration
- `SCREEN_RAM_ARB_STATS_EN` defined:
  - Adds 32-bit output `conflict_count`, which increments on every cycle with `cpu_req` & `scr_req`.
  - It resets to 0 and wraps at 2^32.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Package `screen_ram_pkg`: `owner_t` enum (`OWN_CPU`, `OWN_SCR`) and the `STARVE_CNT_W` = 8 constant.
- Sub-module `rr_arb2`: two-request round-robin picker with urgent override. It is purely combinational, with inputs `req[1:0]`, `urgent` and `last`.

## Test plan
- Reset, then CPU reads address 0x05 containing 0xBEEF → `cpu_gnt` in cycle 0; `cpu_rvalid` = 1 with `cpu_rdata` = 0xBEEF in cycle 1; `scr_rvalid` = 0.
- Both request for 4 cycles with `scr_urgent` = 0 → grants alternate CPU, SCR, CPU, SCR; `rvalid`s follow one cycle later, each to the correct owner.
- `scr_urgent` = 1 with both requesting for 10 cycles, `STARVE_LIMIT` = 8 → `scr_gnt` every cycle; `cpu_starved` rises after the 8th lost cycle; it drops the cycle after urgent falls and the CPU is granted.
- CPU write 0x1234 to 0x10, then screen read of 0x10 → `ram_we` = 1 for one cycle; the following screen read returns 0x1234; no `cpu_rvalid`.
- Reset pulse in the cycle after a screen grant → `scr_rvalid` stays 0; the post-reset tie is granted to the CPU.
- With `SCREEN_RAM_ARB_STATS_EN`: 5 cycles of simultaneous requests → `conflict_count` = 5; reset → 0.
